// File: rtl/interboard_msg_receiver.sv
// Reassembles 4-word move frames from the far board over a 6-bit 4-phase req/ack link.
// Latency: ack/decode follow in_req by SYNC_STAGES+1 edges; rx_valid rises with the W3 ack.
// Backpressure: none upstream; the far board is paced purely by in_ack.
module interboard_msg_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int MAX_MSG_TYPE = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       in_req,
  input  logic [5:0] in_data,
  output logic       in_ack,
  output logic       rx_valid,
  output logic [3:0] rx_msg_type,
  output logic       rx_move_dir,
  output logic [4:0] rx_block_x,
  output logic [2:0] rx_block_y,
  output logic [5:0] rx_card,
  output logic [2:0] rx_sel_len,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     TYPE_MAX = 4'(MAX_MSG_TYPE);

  typedef enum logic [1:0] {S_W0, S_W1, S_W2, S_W3} state_t;

  typedef struct packed {
    logic [3:0] msg_type;
    logic       move_dir;
    logic [4:0] block_x;
    logic [2:0] block_y;
    logic [2:0] sel_len;
  } hdr_t;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   word_stb;

  state_t     state_q, state_nxt;
  hdr_t       shadow_q, shadow_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic       valid_nxt;
  logic       err_nxt;
  logic       rx_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], in_req};
    end
  end

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign word_stb = req_s & ~in_ack;

  // Ack rises on the word strobe and drops once the synchronized request is seen low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ack <= 1'b0;
    end else if (word_stb) begin
      in_ack <= 1'b1;
    end else if (!req_s) begin
      in_ack <= 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    shadow_nxt = shadow_q;
    cnt_nxt    = cnt_q;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    rx_load    = 1'b0;

    if (interboard_rst) begin
      state_nxt  = S_W0;
      shadow_nxt = '0;
      cnt_nxt    = '0;
    end else if (word_stb) begin
      cnt_nxt = '0;
      case (state_q)
        S_W0: begin
          if (in_data[5]) begin
            shadow_nxt.msg_type = in_data[3:0];
            shadow_nxt.move_dir = in_data[4];
            state_nxt           = S_W1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        S_W1: begin
          if (!in_data[5]) begin
            shadow_nxt.block_x = in_data[4:0];
            state_nxt          = S_W2;
          end else begin
            // A header arriving here means the far side restarted; resync onto it.
            err_nxt             = 1'b1;
            shadow_nxt.msg_type = in_data[3:0];
            shadow_nxt.move_dir = in_data[4];
          end
        end
        S_W2: begin
          shadow_nxt.block_y = in_data[5:3];
          shadow_nxt.sel_len = in_data[2:0];
          state_nxt          = S_W3;
        end
        S_W3: begin
          state_nxt = S_W0;
          if (shadow_q.msg_type <= TYPE_MAX) begin
            valid_nxt = 1'b1;
            rx_load   = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = S_W0;
      endcase
    end else if (state_q == S_W0) begin
      cnt_nxt = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_nxt = S_W0;
      err_nxt   = 1'b1;
      cnt_nxt   = '0;
    end else begin
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_W0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      shadow_q  <= shadow_nxt;
      cnt_q     <= cnt_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

  // Card is taken straight from the W3 word since it never lands in the shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_msg_type <= '0;
      rx_move_dir <= 1'b0;
      rx_block_x  <= '0;
      rx_block_y  <= '0;
      rx_card     <= '0;
      rx_sel_len  <= '0;
    end else if (rx_load) begin
      rx_msg_type <= shadow_q.msg_type;
      rx_move_dir <= shadow_q.move_dir;
      rx_block_x  <= shadow_q.block_x;
      rx_block_y  <= shadow_q.block_y;
      rx_card     <= in_data;
      rx_sel_len  <= shadow_q.sel_len;
    end
  end

  assign busy = (state_q != S_W0);

endmodule

// File: tb/tb_interboard_msg_receiver.sv
// Directed bench for interboard_msg_receiver with a frame scoreboard.
module tb_interboard_msg_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       interboard_rst = 1'b0;
  logic       in_req = 1'b0;
  logic [5:0] in_data = '0;
  logic       in_ack;
  logic       rx_valid;
  logic [3:0] rx_msg_type;
  logic       rx_move_dir;
  logic [4:0] rx_block_x;
  logic [2:0] rx_block_y;
  logic [5:0] rx_card;
  logic [2:0] rx_sel_len;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [3:0] t;
    logic       d;
    logic [4:0] bx;
    logic [2:0] by;
    logic [2:0] sl;
    logic [5:0] c;
  } frm_t;

  frm_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int err_seen = 0;
  int exp_valid = 0;
  int exp_err = 0;

  interboard_msg_receiver #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (16),
    .MAX_MSG_TYPE(9)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .interboard_rst(interboard_rst),
    .in_req        (in_req),
    .in_data       (in_data),
    .in_ack        (in_ack),
    .rx_valid      (rx_valid),
    .rx_msg_type   (rx_msg_type),
    .rx_move_dir   (rx_move_dir),
    .rx_block_x    (rx_block_x),
    .rx_block_y    (rx_block_y),
    .rx_card       (rx_card),
    .rx_sel_len    (rx_sel_len),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input frm_t f);
    check({tag, "_type"}, 32'(rx_msg_type), 32'(f.t));
    check({tag, "_dir"},  32'(rx_move_dir), 32'(f.d));
    check({tag, "_bx"},   32'(rx_block_x),  32'(f.bx));
    check({tag, "_by"},   32'(rx_block_y),  32'(f.by));
    check({tag, "_sel"},  32'(rx_sel_len),  32'(f.sl));
    check({tag, "_card"}, 32'(rx_card),     32'(f.c));
  endtask

  // Scoreboard side: every rx_valid consumes one expected frame.
  always @(negedge clk) begin
    if (rx_valid || frame_err) check("pulse_excl", 32'(rx_valid & frame_err), 32'd0);
    if (frame_err) err_seen++;
    if (rx_valid) begin
      valid_seen++;
      check("sb_has_entry", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() > 0) check_fields("sb", exp_q.pop_front());
    end
  end

  task automatic send_word(input logic [5:0] d);
    int n;
    @(posedge clk); #1;
    in_data = d;
    in_req  = 1'b1;
    n = 0;
    while (!in_ack && n < 20) begin @(posedge clk); #1; n++; end
    check("ack_rise_lat", 32'(n), 32'd3);
    in_req = 1'b0;
    n = 0;
    while (in_ack && n < 20) begin @(posedge clk); #1; n++; end
    check("ack_fall_lat", 32'(n), 32'd3);
  endtask

  task automatic send_frame(input frm_t f, input bit good);
    if (good) begin
      exp_q.push_back(f);
      exp_valid++;
    end else begin
      exp_err++;
    end
    send_word({1'b1, f.d, f.t});
    send_word({1'b0, f.bx});
    send_word({f.by, f.sl});
    send_word(f.c);
  endtask

  frm_t f_a, f_b, f_bad, f_c, f_d;

  initial begin
    f_a   = '{t: 4'd9,  d: 1'b1, bx: 5'd12, by: 3'd5, sl: 3'd3, c: 6'd23};
    f_b   = '{t: 4'd3,  d: 1'b0, bx: 5'd31, by: 3'd2, sl: 3'd7, c: 6'h2A};
    f_bad = '{t: 4'd12, d: 1'b0, bx: 5'd5,  by: 3'd0, sl: 3'd0, c: 6'h3F};
    f_c   = '{t: 4'd0,  d: 1'b1, bx: 5'd0,  by: 3'd7, sl: 3'd0, c: 6'd63};
    f_d   = '{t: 4'd5,  d: 1'b0, bx: 5'd17, by: 3'd1, sl: 3'd4, c: 6'd9};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(in_ack), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_fields("rst", '{t: 4'd0, d: 1'b0, bx: 5'd0, by: 3'd0, sl: 3'd0, c: 6'd0});
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Good frame
    send_frame(f_a, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("a_valid_cnt", 32'(valid_seen), 32'(exp_valid));
    check("a_err_cnt", 32'(err_seen), 32'(exp_err));
    check_fields("a_hold", f_a);
    check("a_busy", 32'(busy), 32'd0);

    // Bad start, then a good frame
    exp_err++;
    send_word(6'h05);
    check("bad_busy", 32'(busy), 32'd0);
    check("bad_err_cnt", 32'(err_seen), 32'(exp_err));
    send_frame(f_b, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("b_valid_cnt", 32'(valid_seen), 32'(exp_valid));

    // Illegal msg_type keeps previous fields
    send_frame(f_bad, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("ill_err_cnt", 32'(err_seen), 32'(exp_err));
    check("ill_valid_cnt", 32'(valid_seen), 32'(exp_valid));
    check_fields("ill_hold", f_b);

    // Timeout after W1
    send_word(6'h21);
    send_word(6'h02);
    repeat (8) @(posedge clk); #1;
    check("to_busy_early", 32'(busy), 32'd1);
    check("to_err_early", 32'(err_seen), 32'(exp_err));
    repeat (7) @(posedge clk); #1;
    exp_err++;
    check("to_busy_late", 32'(busy), 32'd0);
    check("to_err_late", 32'(err_seen), 32'(exp_err));
    exp_err++;
    send_word(6'h1A);
    repeat (2) @(posedge clk); #1;
    check("late_w2_err", 32'(err_seen), 32'(exp_err));
    check("late_w2_busy", 32'(busy), 32'd0);

    // interboard_rst after W2, then a word swallowed by a held interboard_rst
    send_word(6'h25);
    send_word(6'h03);
    send_word(6'h08);
    check("ibr_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #1;
    interboard_rst = 1'b1;
    @(posedge clk); #1;
    interboard_rst = 1'b0;
    check("ibr_busy_post", 32'(busy), 32'd0);
    interboard_rst = 1'b1;
    send_word(6'h11);
    interboard_rst = 1'b0;
    check("ibr_drop_err", 32'(err_seen), 32'(exp_err));
    check("ibr_drop_busy", 32'(busy), 32'd0);
    send_frame(f_c, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("c_valid_cnt", 32'(valid_seen), 32'(exp_valid));
    check_fields("c_hold", f_c);

    // Async reset mid-handshake
    @(posedge clk); #1;
    in_data = 6'h21;
    in_req  = 1'b1;
    begin
      int n = 0;
      while (!in_ack && n < 20) begin @(posedge clk); #1; n++; end
      check("mid_ack_up", 32'(in_ack), 32'd1);
    end
    check("mid_busy_up", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_ack_drop", 32'(in_ack), 32'd0);
    check("mid_busy_drop", 32'(busy), 32'd0);
    check_fields("mid_rx", '{t: 4'd0, d: 1'b0, bx: 5'd0, by: 3'd0, sl: 3'd0, c: 6'd0});
    in_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    send_frame(f_d, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("d_valid_cnt", 32'(valid_seen), 32'(exp_valid));
    check("final_err_cnt", 32'(err_seen), 32'(exp_err));
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
